// File: rtl/range_mask_gen_pkg.sv
// Shared payload type and width-derived constants for range_mask_gen.
// The invert bit in the S1 payload exists only when RANGE_MASK_GEN_INVERT_EN is defined.
package range_mask_gen_pkg;

    localparam int unsigned RMG_WIDTH = 8;
    localparam int unsigned RMG_IDX_W = $clog2(RMG_WIDTH);
    localparam int unsigned RMG_CNT_W = RMG_IDX_W + 1;

    // Payload is sized by RMG_WIDTH; the top's WIDTH parameter must stay equal to it.
    typedef struct packed {
        logic [RMG_WIDTH-1:0] therm;
        logic [RMG_IDX_W-1:0] start;
        logic                 overflow;
`ifdef RANGE_MASK_GEN_INVERT_EN
        logic                 invert;
`endif
    } s1_payload_t;

endpackage

// File: rtl/range_mask_gen_rotate.sv
// Combinational circular left-rotate of a WIDTH-bit vector (WIDTH a power of two).
module range_mask_gen_rotate #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(WIDTH)-1:0] i_shift,
    output logic [WIDTH-1:0]         o_data
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    // Index arithmetic wraps naturally because WIDTH is a power of two.
    always_comb begin
        o_data = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_data[i] = i_data[IDX_W'(i) - i_shift];
        end
    end

endmodule

// File: rtl/range_mask_gen.sv
// Two-stage pipelined circular range mask generator with valid/ready handshakes.
// Optional output inversion is enabled by defining RANGE_MASK_GEN_INVERT_EN.
module range_mask_gen
    import range_mask_gen_pkg::*;
#(
    parameter int unsigned WIDTH = RMG_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(WIDTH)-1:0] start,
    input  logic [$clog2(WIDTH):0]   count,
`ifdef RANGE_MASK_GEN_INVERT_EN
    input  logic                     invert,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         mask,
    output logic                     overflow
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic             r_s1_valid;
    s1_payload_t      r_s1;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_mask;
    logic             r_s2_overflow;
`ifdef RANGE_MASK_GEN_INVERT_EN
    logic             r_s2_invert;
`endif

    s1_payload_t      w_s1_d;
    logic             w_s1_advance;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_rotated;

    assign w_s1_advance = !r_s2_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s1_advance;
    assign w_in_fire    = in_valid && in_ready;

    // Right-aligned thermometer of min(count, WIDTH) ones.
    always_comb begin
        w_s1_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_s1_d.therm[i] = (CNT_W'(i) < count);
        end
        w_s1_d.start    = start;
        w_s1_d.overflow = (count > CNT_W'(WIDTH));
`ifdef RANGE_MASK_GEN_INVERT_EN
        w_s1_d.invert   = invert;
`endif
    end

    range_mask_gen_rotate #(
        .WIDTH (WIDTH)
    ) u_rotate (
        .i_data  (r_s1.therm),
        .i_shift (r_s1.start),
        .o_data  (w_rotated)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1          <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_mask     <= '0;
            r_s2_overflow <= 1'b0;
`ifdef RANGE_MASK_GEN_INVERT_EN
            r_s2_invert   <= 1'b0;
`endif
        end else begin
            // Flush wins over every advance; a same-cycle output handshake still completes.
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
            end else begin
                if (in_ready) begin
                    r_s1_valid <= in_valid;
                end
                if (w_s1_advance) begin
                    r_s2_valid <= r_s1_valid;
                end
            end
            if (w_in_fire) begin
                r_s1 <= w_s1_d;
            end
            if (w_s1_advance && r_s1_valid) begin
                r_s2_mask     <= w_rotated;
                r_s2_overflow <= r_s1.overflow;
`ifdef RANGE_MASK_GEN_INVERT_EN
                r_s2_invert   <= r_s1.invert;
`endif
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign overflow  = r_s2_overflow;
`ifdef RANGE_MASK_GEN_INVERT_EN
    assign mask      = r_s2_mask ^ {WIDTH{r_s2_invert}};
`else
    assign mask      = r_s2_mask;
`endif

endmodule
